// File: rtl/linreg_sum_accumulator.sv
// Accumulates sum_x, sum_y, sum_xy, sum_xx over NUM_SAMPLES (x, y) handshakes, then holds totals in DONE.
// Latency 1 per accepted sample; in_ready high only in ACCUM, so upstream stalls in IDLE/DONE.
module linreg_sum_accumulator #(
    parameter int N           = 32,
    parameter int ACC_W       = 72,
    parameter int NUM_SAMPLES = 150,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [N-1:0]     x_in,
    input  logic signed [N-1:0]     y_in,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        count,
    output logic signed [ACC_W-1:0] sum_x,
    output logic signed [ACC_W-1:0] sum_y,
    output logic signed [ACC_W-1:0] sum_xy,
    output logic signed [ACC_W-1:0] sum_xx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                   handshake;
    logic                   last_sample;
    logic                   clear;
    logic signed [2*N-1:0]  prod_xy;
    logic signed [2*N-1:0]  prod_xx;

    assign handshake   = in_valid && (state == ACCUM);
    assign last_sample = (count == CNT_W'(NUM_SAMPLES - 1));
    // A start is only honoured outside ACCUM; a run in progress cannot be restarted.
    assign clear       = start && (state != ACCUM);

    // Operands widened first so the full 2N-bit signed product is kept.
    assign prod_xy = (2*N)'(x_in) * (2*N)'(y_in);
    assign prod_xx = (2*N)'(x_in) * (2*N)'(x_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (handshake && last_sample) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = ACCUM;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            sum_x  <= '0;
            sum_y  <= '0;
            sum_xy <= '0;
            sum_xx <= '0;
        end else if (clear) begin
            count  <= '0;
            sum_x  <= '0;
            sum_y  <= '0;
            sum_xy <= '0;
            sum_xx <= '0;
        end else if (handshake) begin
            count  <= count + CNT_W'(1);
            sum_x  <= sum_x  + ACC_W'(x_in);
            sum_y  <= sum_y  + ACC_W'(y_in);
            sum_xy <= sum_xy + ACC_W'(prod_xy);
            sum_xx <= sum_xx + ACC_W'(prod_xx);
        end
    end

endmodule

// File: tb/tb_linreg_sum_accumulator.sv
// Bench for linreg_sum_accumulator with NUM_SAMPLES=4: table vectors, corner sequences, random runs vs a sum model.
module tb_linreg_sum_accumulator;

    localparam int N     = 32;
    localparam int ACC_W = 72;
    localparam int NS    = 4;
    localparam int CNT_W = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [N-1:0]     x_in;
    logic signed [N-1:0]     y_in;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        count;
    logic signed [ACC_W-1:0] sum_x;
    logic signed [ACC_W-1:0] sum_y;
    logic signed [ACC_W-1:0] sum_xy;
    logic signed [ACC_W-1:0] sum_xx;

    int checks = 0;
    int errors = 0;

    // Reference model: samples of the current run and their running moments.
    logic signed [N-1:0]     sx [NS];
    logic signed [N-1:0]     sy [NS];
    logic signed [ACC_W-1:0] mx, my, mxy, mxx;
    int                      nacc;

    typedef struct {
        logic [3:0][N-1:0]       x;
        logic [3:0][N-1:0]       y;
        logic [31:0]             pat;
        logic signed [ACC_W-1:0] ex;
        logic signed [ACC_W-1:0] ey;
        logic signed [ACC_W-1:0] exy;
        logic signed [ACC_W-1:0] exx;
    } vec_t;

    vec_t tv [5];

    linreg_sum_accumulator #(
        .N(N), .ACC_W(ACC_W), .NUM_SAMPLES(NS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .busy(busy), .done(done), .count(count),
        .sum_x(sum_x), .sum_y(sum_y), .sum_xy(sum_xy), .sum_xx(sum_xx)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] flags_exp);
        chk({tag, "_count"},  ACC_W'(count), ACC_W'(nacc));
        chk({tag, "_flags"},  ACC_W'({in_ready, busy, done}), ACC_W'(flags_exp));
        chk({tag, "_sum_x"},  sum_x,  mx);
        chk({tag, "_sum_y"},  sum_y,  my);
        chk({tag, "_sum_xy"}, sum_xy, mxy);
        chk({tag, "_sum_xx"}, sum_xx, mxx);
    endtask

    task automatic model_clear();
        mx = '0; my = '0; mxy = '0; mxx = '0; nacc = 0;
    endtask

    task automatic do_start(input string tag);
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        model_clear();
        chk_state({tag, "_start"}, 3'b110);
    endtask

    // Called at a falling edge; feeds samples sx/sy following the valid pattern until nstop are accepted.
    task automatic feed(input string tag, input logic [31:0] pat, input int nstop);
        logic v;
        for (int c = 0; c < 32 && nacc < nstop; c++) begin
            v        = pat[c] || (c >= 24);
            in_valid = v;
            x_in     = v ? sx[nacc] : $urandom;
            y_in     = v ? sy[nacc] : $urandom;
            @(negedge clk);
            if (v) begin
                mx  += ACC_W'(sx[nacc]);
                my  += ACC_W'(sy[nacc]);
                mxy += ACC_W'(sx[nacc]) * ACC_W'(sy[nacc]);
                mxx += ACC_W'(sx[nacc]) * ACC_W'(sx[nacc]);
                nacc++;
            end
            chk_state(tag, (nacc < NS) ? 3'b110 : 3'b001);
        end
        in_valid = 1'b0;
    endtask

    task automatic randomize_samples();
        for (int i = 0; i < NS; i++) begin
            sx[i] = $urandom;
            sy[i] = $urandom;
        end
    endtask

    initial begin
        tv[0] = '{x: {32'sd4, 32'sd3, 32'sd2, 32'sd1}, y: {32'sd8, 32'sd6, 32'sd4, 32'sd2},
                  pat: 32'h0000000F, ex: 72'sd10, ey: 72'sd20, exy: 72'sd60, exx: 72'sd30};
        tv[1] = '{x: {32'sd4, 32'sd3, 32'sd2, 32'sd1}, y: {32'sd8, 32'sd6, 32'sd4, 32'sd2},
                  pat: 32'h00000069, ex: 72'sd10, ey: 72'sd20, exy: 72'sd60, exx: 72'sd30};
        tv[2] = '{x: {32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000},
                  y: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                  pat: 32'h0000000F, ex: -72'sd8589934592, ey: -72'sd4,
                  exy: 72'sd8589934592, exx: 72'h01_0000_0000_0000_0000};
        tv[3] = '{x: {32'sd100, 32'sd0, -32'sd7, 32'sd5}, y: {-32'sd100, 32'sd9, 32'sd2, -32'sd3},
                  pat: 32'h00000055, ex: 72'sd98, ey: -72'sd92, exy: -72'sd10029, exx: 72'sd10074};
        tv[4] = '{x: {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF},
                  y: {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF},
                  pat: 32'h0000000F, ex: 72'sd8589934588, ey: 72'sd8589934588,
                  exy: 72'h00_FFFF_FFFC_0000_0004, exx: 72'h00_FFFF_FFFC_0000_0004};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0;
        model_clear();
        #2;
        chk_state("reset", 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_state("idle", 3'b000);

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < NS; i++) begin
                sx[i] = tv[t].x[i];
                sy[i] = tv[t].y[i];
            end
            do_start($sformatf("tv%0d", t));
            feed($sformatf("tv%0d", t), tv[t].pat, NS);
            chk($sformatf("tv%0d_final_sum_x", t),  sum_x,  tv[t].ex);
            chk($sformatf("tv%0d_final_sum_y", t),  sum_y,  tv[t].ey);
            chk($sformatf("tv%0d_final_sum_xy", t), sum_xy, tv[t].exy);
            chk($sformatf("tv%0d_final_sum_xx", t), sum_xx, tv[t].exx);
        end

        // Samples offered in DONE must be ignored.
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            x_in     = $urandom;
            y_in     = $urandom;
            @(negedge clk);
            chk_state("done_hold", 3'b001);
        end
        in_valid = 1'b0;

        // start while accumulating is ignored.
        randomize_samples();
        do_start("ign");
        feed("ign_a", 32'h0000000F, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_state("ign_start", 3'b110);
        feed("ign_b", 32'h0000000F, NS);

        // Asynchronous reset after two samples discards the run.
        randomize_samples();
        do_start("rst");
        feed("rst_a", 32'h0000000F, 2);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        chk_state("rst_async", 3'b000);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_state("rst_idle", 3'b000);
        end
        randomize_samples();
        do_start("rst_rerun");
        feed("rst_rerun", 32'h0000000F, NS);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        model_clear();
        chk_state("rst_start", 3'b000);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_state("rst_start_idle", 3'b000);

        for (int r = 0; r < 20; r++) begin
            randomize_samples();
            do_start($sformatf("rnd%0d", r));
            feed($sformatf("rnd%0d", r), $urandom, NS);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
